// File: rtl/lift_ctrl.sv
// Three-floor lift motion controller: call latching, direction-preference scheduling,
// travel and door timing on slowref ticks. Define LIFT_DOOR_HOLD_EN to add the door_hold input.
module lift_ctrl #(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       slowref,
  input  logic [2:0] callbtn,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [1:0] floorno,
  output logic [2:0] pending,
  output logic       mov_up,
  output logic       mov_dn,
  output logic       door_open
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_up;

  logic [2:0] cur_sel;
  logic [2:0] call_lat;
  logic [2:0] pend_in;
  logic [1:0] arr_fl;
  logic [2:0] arr_sel;
  logic       hold;
  logic       idle_above;
  logic       idle_below;
  logic       arr_more;

  function automatic logic [2:0] flr_mask(input logic [1:0] f);
    case (f)
      2'd0:    flr_mask = 3'b001;
      2'd1:    flr_mask = 3'b010;
      2'd2:    flr_mask = 3'b100;
      default: flr_mask = 3'b000;
    endcase
  endfunction

  function automatic logic calls_above(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd0:    calls_above = p[1] | p[2];
      2'd1:    calls_above = p[2];
      default: calls_above = 1'b0;
    endcase
  endfunction

  function automatic logic calls_below(input logic [1:0] f, input logic [2:0] p);
    case (f)
      2'd2:    calls_below = p[0] | p[1];
      2'd1:    calls_below = p[0];
      default: calls_below = 1'b0;
    endcase
  endfunction

  always_comb begin
    cur_sel    = flr_mask(floorno);
    // A call for the floor whose door is open only restarts the dwell timer.
    call_lat   = callbtn & ((state == DOOR) ? ~cur_sel : 3'b111);
    pend_in    = pending | call_lat;
    arr_fl     = (state == MOVE_UP) ? floorno + 2'd1 : floorno - 2'd1;
    arr_sel    = flr_mask(arr_fl);
    idle_above = calls_above(floorno, pending);
    idle_below = calls_below(floorno, pending);
    arr_more   = (state == MOVE_UP) ? calls_above(arr_fl, pend_in)
                                    : calls_below(arr_fl, pend_in);
`ifdef LIFT_DOOR_HOLD_EN
    hold       = door_hold;
`else
    hold       = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      floorno   <= 2'd0;
      pending   <= 3'b000;
      cnt       <= '0;
      dir_up    <= 1'b1;
      mov_up    <= 1'b0;
      mov_dn    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      pending <= pend_in;
      case (state)
        IDLE: begin
          if (|(pending & cur_sel)) begin
            state     <= DOOR;
            door_open <= 1'b1;
            cnt       <= '0;
            pending   <= pend_in & ~cur_sel;
          end else if (idle_above && (!idle_below || dir_up)) begin
            state  <= MOVE_UP;
            mov_up <= 1'b1;
            dir_up <= 1'b1;
            cnt    <= '0;
          end else if (idle_below) begin
            state  <= MOVE_DN;
            mov_dn <= 1'b1;
            dir_up <= 1'b0;
            cnt    <= '0;
          end
        end

        MOVE_UP, MOVE_DN: begin
          if (slowref) begin
            if (cnt == TRAVEL_LAST) begin
              cnt     <= '0;
              floorno <= arr_fl;
              if (|(pend_in & arr_sel)) begin
                state     <= DOOR;
                door_open <= 1'b1;
                mov_up    <= 1'b0;
                mov_dn    <= 1'b0;
                pending   <= pend_in & ~arr_sel;
              end else if (!arr_more) begin
                state  <= IDLE;
                mov_up <= 1'b0;
                mov_dn <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        DOOR: begin
          if (|(callbtn & cur_sel) || hold) begin
            cnt <= '0;
          end else if (slowref) begin
            if (cnt == DOOR_LAST) begin
              state     <= IDLE;
              door_open <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state     <= IDLE;
          mov_up    <= 1'b0;
          mov_dn    <= 1'b0;
          door_open <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_ctrl.sv
// Directed bench for lift_ctrl: table of {inputs, cycles, expected outputs} steps,
// then hand sequences for asynchronous reset mid-travel and the door hold option.
module tb_lift_ctrl;

  logic       clk = 1'b0;
  logic       resetb;
  logic       slowref;
  logic [2:0] callbtn;
`ifdef LIFT_DOOR_HOLD_EN
  logic       door_hold;
`endif
  logic [1:0] floorno;
  logic [2:0] pending;
  logic       mov_up;
  logic       mov_dn;
  logic       door_open;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rb;
    logic       sr;
    logic [2:0] cb;
    int         n;
    logic [1:0] fl;
    logic [2:0] pd;
    logic       up;
    logic       dn;
    logic       dr;
  } vec_t;

  vec_t vq[$];

  lift_ctrl #(.TRAVEL_TICKS(4), .DOOR_TICKS(3), .CNT_W(4)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .slowref  (slowref),
    .callbtn  (callbtn),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .floorno  (floorno),
    .pending  (pending),
    .mov_up   (mov_up),
    .mov_dn   (mov_dn),
    .door_open(door_open)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (floorno == 2'b11) begin
      errors++;
      $display("FAIL floorno_range got %b want not 11", floorno);
    end
  end

  task automatic add(input logic rb, input logic sr, input logic [2:0] cb, input int n,
                     input logic [1:0] fl, input logic [2:0] pd,
                     input logic up, input logic dn, input logic dr);
    vec_t v;
    v.rb = rb; v.sr = sr; v.cb = cb; v.n = n;
    v.fl = fl; v.pd = pd; v.up = up; v.dn = dn; v.dr = dr;
    vq.push_back(v);
  endtask

  task automatic cyc(input logic rb, input logic sr, input logic [2:0] cb);
    @(negedge clk);
    resetb  = rb;
    slowref = sr;
    callbtn = cb;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] fl, input logic [2:0] pd,
                       input logic up, input logic dn, input logic dr);
    logic [7:0] act;
    logic [7:0] exp;
    act = {floorno, pending, mov_up, mov_dn, door_open};
    exp = {fl, pd, up, dn, dr};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got fl/pend/up/dn/door=%b want %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb  = 1'b0;
    slowref = 1'b0;
    callbtn = 3'b000;
`ifdef LIFT_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif

    //  rb  sr  cb      n   fl    pd      up  dn  dr
    // reset held while inputs toggle, then release
    add(0, 1, 3'b111, 3, 2'd0, 3'b000, 0, 0, 0);
    add(1, 0, 3'b000, 2, 2'd0, 3'b000, 0, 0, 0);
    // call floor 2 from floor 0
    add(1, 0, 3'b100, 1, 2'd0, 3'b100, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd0, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 3, 2'd0, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 1, 2'd1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 3, 2'd1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 1, 2'd2, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 2, 2'd2, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 1, 2'd2, 3'b000, 0, 0, 0);
    add(1, 0, 3'b000, 2, 2'd2, 3'b000, 0, 0, 0);
    // back down to floor 0, passing floor 1
    add(1, 0, 3'b001, 1, 2'd2, 3'b001, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd2, 3'b001, 0, 1, 0);
    add(1, 1, 3'b000, 4, 2'd1, 3'b001, 0, 1, 0);
    add(1, 1, 3'b000, 4, 2'd0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd0, 3'b000, 0, 0, 0);
    // intermediate stop at floor 1 while heading to 2
    add(1, 0, 3'b100, 1, 2'd0, 3'b100, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd0, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 2, 2'd0, 3'b100, 1, 0, 0);
    add(1, 1, 3'b010, 1, 2'd0, 3'b110, 1, 0, 0);
    add(1, 1, 3'b000, 1, 2'd1, 3'b100, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd1, 3'b100, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd1, 3'b100, 1, 0, 0);
    add(1, 1, 3'b000, 4, 2'd2, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd2, 3'b000, 0, 0, 0);
    // go to floor 0, then up to floor 1 so dir=up at floor 1
    add(1, 0, 3'b001, 2, 2'd2, 3'b001, 0, 1, 0);
    add(1, 1, 3'b000, 8, 2'd0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd0, 3'b000, 0, 0, 0);
    add(1, 0, 3'b010, 2, 2'd0, 3'b010, 1, 0, 0);
    add(1, 1, 3'b000, 4, 2'd1, 3'b000, 0, 0, 1);
    // calls above and below latch during door; up is served first
    add(1, 0, 3'b101, 1, 2'd1, 3'b101, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd1, 3'b101, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd1, 3'b101, 1, 0, 0);
    add(1, 1, 3'b000, 4, 2'd2, 3'b001, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd2, 3'b001, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd2, 3'b001, 0, 1, 0);
    add(1, 1, 3'b000, 4, 2'd1, 3'b001, 0, 1, 0);
    add(1, 1, 3'b000, 4, 2'd0, 3'b000, 0, 0, 1);
    // door restart: call for the open floor after 2 ticks
    add(1, 1, 3'b000, 2, 2'd0, 3'b000, 0, 0, 1);
    add(1, 0, 3'b001, 1, 2'd0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 2, 2'd0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 1, 2'd0, 3'b000, 0, 0, 0);
    // call at the current floor while idle opens the door
    add(1, 0, 3'b001, 1, 2'd0, 3'b001, 0, 0, 0);
    add(1, 0, 3'b000, 1, 2'd0, 3'b000, 0, 0, 1);
    add(1, 1, 3'b000, 3, 2'd0, 3'b000, 0, 0, 0);

    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].n; k++) cyc(vq[i].rb, vq[i].sr, vq[i].cb);
      check($sformatf("step%0d", i), vq[i].fl, vq[i].pd, vq[i].up, vq[i].dn, vq[i].dr);
    end

    // asynchronous reset between floors 1 and 2
    cyc(1, 0, 3'b100);
    cyc(1, 0, 3'b100);
    for (int k = 0; k < 6; k++) cyc(1, 1, 3'b000);
    check("mid_move", 2'd1, 3'b100, 1, 0, 0);
    @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    check("async_rst", 2'd0, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3'b111);
      check($sformatf("rst_hold%0d", k), 2'd0, 3'b000, 0, 0, 0);
    end
    cyc(1, 0, 3'b000);
    cyc(1, 0, 3'b000);
    check("rst_release", 2'd0, 3'b000, 0, 0, 0);

`ifdef LIFT_DOOR_HOLD_EN
    cyc(1, 0, 3'b001);
    cyc(1, 0, 3'b000);
    check("hold_door_enter", 2'd0, 3'b000, 0, 0, 1);
    door_hold = 1'b1;
    for (int k = 0; k < 10; k++) cyc(1, 1, 3'b000);
    check("hold_10_ticks", 2'd0, 3'b000, 0, 0, 1);
    door_hold = 1'b0;
    cyc(1, 1, 3'b000);
    cyc(1, 1, 3'b000);
    check("hold_release_2", 2'd0, 3'b000, 0, 0, 1);
    cyc(1, 1, 3'b000);
    check("hold_release_3", 2'd0, 3'b000, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
